// File: rtl/riscv_ctrl_axil_slave.sv
// AXI4-lite register block for the riscv_example kernel control path:
// ap_* handshake, interrupt enable/status and kernel argument registers.
module riscv_ctrl_axil_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  ap_start,
    input  logic                  ap_done,
    input  logic                  ap_idle,
    input  logic                  ap_ready,
    output logic                  interrupt,
    output logic [31:0]           reset_riscv,
    output logic [31:0]           interrupt_riscv,
    output logic [31:0]           ABS_ADDRESS,
    output logic [31:0]           SAMPLE,
    output logic [63:0]           dBus,
    output logic [63:0]           iBus
);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state, w_state_next;
    r_state_t              r_state, r_state_next;
    logic                  aw_have, aw_have_next, w_have, w_have_next;
    logic [4:0]            aw_index_q, aw_index_next;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_next;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_next;
    logic                  awready_next, wready_next, bvalid_next;
    logic                  arready_next, rvalid_next;
    logic [DATA_WIDTH-1:0] rdata_next, rd_mux;
    logic                  wr_en;
    logic [4:0]            wr_index;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  aw_hs, w_hs, ar_hs, ctrl_rd;
    logic                  wr_ctrl, wr_gie, wr_ier, wr_isr;
    logic                  auto_restart, done_latch, ready_latch, gie;
    logic [1:0]            ier, isr;
    logic                  unused_ok;

    assign aw_hs   = s_axil_awvalid & s_axil_awready;
    assign w_hs    = s_axil_wvalid & s_axil_wready;
    assign ar_hs   = s_axil_arvalid & s_axil_arready;
    assign ctrl_rd = ar_hs && (s_axil_araddr[6:2] == 5'd0);
    assign wr_ctrl = wr_en && (wr_index == 5'd0);
    assign wr_gie  = wr_en && (wr_index == 5'd1);
    assign wr_ier  = wr_en && (wr_index == 5'd2);
    assign wr_isr  = wr_en && (wr_index == 5'd3);

    assign s_axil_bresp = 2'b00;
    assign s_axil_rresp = 2'b00;
    assign unused_ok    = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    // Merge new data into an old register value, one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Write FSM next state: collect AW and W independently, commit once both are held.
    always_comb begin
        w_state_next  = w_state;
        aw_have_next  = aw_have;
        w_have_next   = w_have;
        aw_index_next = aw_index_q;
        w_data_next   = w_data_q;
        w_strb_next   = w_strb_q;
        bvalid_next   = s_axil_bvalid;
        wr_en         = 1'b0;
        wr_index      = aw_index_q;
        wr_data       = w_data_q;
        wr_strb       = w_strb_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_have_next  = 1'b1;
                    aw_index_next = s_axil_awaddr[6:2];
                end
                if (w_hs) begin
                    w_have_next = 1'b1;
                    w_data_next = s_axil_wdata;
                    w_strb_next = s_axil_wstrb;
                end
                if (aw_have_next && w_have_next) begin
                    wr_en        = 1'b1;
                    wr_index     = aw_index_next;
                    wr_data      = w_data_next;
                    wr_strb      = w_strb_next;
                    aw_have_next = 1'b0;
                    w_have_next  = 1'b0;
                    bvalid_next  = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    bvalid_next  = 1'b0;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
        awready_next = (w_state_next == W_IDLE) && !aw_have_next;
        wready_next  = (w_state_next == W_IDLE) && !w_have_next;
    end

    // Write FSM state register; ready flags are registered so they sit low during reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state        <= W_IDLE;
            aw_have        <= 1'b0;
            w_have         <= 1'b0;
            aw_index_q     <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
        end else begin
            w_state        <= w_state_next;
            aw_have        <= aw_have_next;
            w_have         <= w_have_next;
            aw_index_q     <= aw_index_next;
            w_data_q       <= w_data_next;
            w_strb_q       <= w_strb_next;
            s_axil_awready <= awready_next;
            s_axil_wready  <= wready_next;
            s_axil_bvalid  <= bvalid_next;
        end
    end

    // Read data mux over the register map; unmapped offsets read as zero.
    always_comb begin
        rd_mux = '0;
        case (s_axil_araddr[6:2])
            5'd0:  rd_mux = {24'd0, auto_restart, 3'd0, ready_latch, ap_idle, done_latch, ap_start};
            5'd1:  rd_mux = {31'd0, gie};
            5'd2:  rd_mux = {30'd0, ier};
            5'd3:  rd_mux = {30'd0, isr};
            5'd4:  rd_mux = reset_riscv;
            5'd6:  rd_mux = interrupt_riscv;
            5'd8:  rd_mux = ABS_ADDRESS;
            5'd10: rd_mux = SAMPLE;
            5'd12: rd_mux = dBus[31:0];
            5'd13: rd_mux = dBus[63:32];
            5'd15: rd_mux = iBus[31:0];
            5'd16: rd_mux = iBus[63:32];
            default: rd_mux = '0;
        endcase
    end

    // Read FSM next state: capture data on the AR handshake, hold until rready.
    always_comb begin
        r_state_next = r_state;
        rvalid_next  = s_axil_rvalid;
        rdata_next   = s_axil_rdata;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_next   = rd_mux;
                    rvalid_next  = 1'b1;
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rvalid_next  = 1'b0;
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
        arready_next = (r_state_next == R_IDLE);
    end

    // Read FSM state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state        <= R_IDLE;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
        end else begin
            r_state        <= r_state_next;
            s_axil_arready <= arready_next;
            s_axil_rvalid  <= rvalid_next;
            s_axil_rdata   <= rdata_next;
        end
    end

    // Control handshake: start is only ever set by the host, latches set wins over clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start     <= 1'b0;
            auto_restart <= 1'b0;
            done_latch   <= 1'b0;
            ready_latch  <= 1'b0;
        end else begin
            if (wr_ctrl && wr_strb[0] && wr_data[0]) ap_start <= 1'b1;
            else if (ap_ready && !auto_restart)      ap_start <= 1'b0;
            if (wr_ctrl && wr_strb[0]) auto_restart <= wr_data[7];
            if (ap_done)      done_latch <= 1'b1;
            else if (ctrl_rd) done_latch <= 1'b0;
            if (ap_ready)     ready_latch <= 1'b1;
            else if (ctrl_rd) ready_latch <= 1'b0;
        end
    end

    // Interrupt enables and status; a hardware set beats a same-cycle W1C.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gie       <= 1'b0;
            ier       <= 2'b00;
            isr       <= 2'b00;
            interrupt <= 1'b0;
        end else begin
            if (wr_gie && wr_strb[0]) gie <= wr_data[0];
            if (wr_ier && wr_strb[0]) ier <= wr_data[1:0];
            if (ap_done && ier[0])                      isr[0] <= 1'b1;
            else if (wr_isr && wr_strb[0] && wr_data[0]) isr[0] <= 1'b0;
            if (ap_ready && ier[1])                     isr[1] <= 1'b1;
            else if (wr_isr && wr_strb[0] && wr_data[1]) isr[1] <= 1'b0;
            interrupt <= gie & (isr[0] | isr[1]);
        end
    end

    // Kernel argument registers with per-byte write strobes.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            reset_riscv     <= '0;
            interrupt_riscv <= '0;
            ABS_ADDRESS     <= '0;
            SAMPLE          <= '0;
            dBus            <= '0;
            iBus            <= '0;
        end else if (wr_en) begin
            case (wr_index)
                5'd4:  reset_riscv     <= apply_strb(reset_riscv, wr_data, wr_strb);
                5'd6:  interrupt_riscv <= apply_strb(interrupt_riscv, wr_data, wr_strb);
                5'd8:  ABS_ADDRESS     <= apply_strb(ABS_ADDRESS, wr_data, wr_strb);
                5'd10: SAMPLE          <= apply_strb(SAMPLE, wr_data, wr_strb);
                5'd12: dBus[31:0]      <= apply_strb(dBus[31:0], wr_data, wr_strb);
                5'd13: dBus[63:32]     <= apply_strb(dBus[63:32], wr_data, wr_strb);
                5'd15: iBus[31:0]      <= apply_strb(iBus[31:0], wr_data, wr_strb);
                5'd16: iBus[63:32]     <= apply_strb(iBus[63:32], wr_data, wr_strb);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_ctrl_axil_slave.sv
// Directed self-checking bench for riscv_ctrl_axil_slave.
module tb_riscv_ctrl_axil_slave;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [7:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [7:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        ap_start;
    logic        ap_done = 1'b0;
    logic        ap_idle = 1'b0;
    logic        ap_ready = 1'b0;
    logic        interrupt;
    logic [31:0] reset_riscv, interrupt_riscv, ABS_ADDRESS, SAMPLE;
    logic [63:0] dBus, iBus;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_ctrl_axil_slave dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .interrupt(interrupt),
        .reset_riscv(reset_riscv), .interrupt_riscv(interrupt_riscv),
        .ABS_ADDRESS(ABS_ADDRESS), .SAMPLE(SAMPLE), .dBus(dBus), .iBus(iBus)
    );

    always #5 ap_clk = ~ap_clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Full write transaction; called and returns at a falling edge, bready held high.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge ap_clk); cyc++;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid = 1'b0;  w_done = 1;  end
        end
        cyc = 0;
        while (!bvalid && cyc < 20) begin @(negedge ap_clk); cyc++; end
        n_tests++;
        if (!(aw_done && w_done && bvalid)) begin
            n_fail++;
            $display("[TB] FAIL write_timeout addr %h: got bvalid %b required 1", addr, bvalid);
            awvalid = 1'b0; wvalid = 1'b0;
        end else begin
            @(negedge ap_clk);
        end
    endtask

    // Full read transaction; called and returns at a falling edge, rready held high.
    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        araddr = addr; arvalid = 1'b1;
        while (!arready && cyc < 20) begin @(negedge ap_clk); cyc++; end
        @(negedge ap_clk);
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 20) begin @(negedge ap_clk); cyc++; end
        data = rdata; resp = rresp;
        n_tests++;
        if (!rvalid) begin
            n_fail++;
            $display("[TB] FAIL read_timeout addr %h: got rvalid %b required 1", addr, rvalid);
        end else begin
            @(negedge ap_clk);
        end
    endtask

    task automatic test_reset;
        @(negedge ap_clk); @(negedge ap_clk);
        n_tests++;
        if ({awready, wready, bvalid, arready, rvalid, ap_start, interrupt} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake: got %b required 0000000",
                     {awready, wready, bvalid, arready, rvalid, ap_start, interrupt});
        end
        n_tests++;
        if ({rdata, reset_riscv, interrupt_riscv, ABS_ADDRESS, SAMPLE, dBus, iBus} !== 288'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: got rdata %h abs %h dbus %h ibus %h required all 0",
                     rdata, ABS_ADDRESS, dBus, iBus);
        end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL ready_after_reset: got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_write_read;
        awaddr = 8'h20; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge ap_clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n_tests++;
        if ({bvalid, awready, wready} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL same_cycle_bvalid: got bvalid/awready/wready %b required 100",
                     {bvalid, awready, wready});
        end
        n_tests++;
        if (ABS_ADDRESS !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL abs_address: got %h required deadbeef", ABS_ADDRESS);
        end
        @(negedge ap_clk);
        n_tests++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bvalid_release: got %b required 0", bvalid);
        end
        araddr = 8'h20; arvalid = 1'b1;
        @(negedge ap_clk);
        arvalid = 1'b0;
        n_tests++;
        if ({rvalid, rdata, rresp} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL read_abs: got rvalid %b rdata %h rresp %b required 1 deadbeef 00",
                     rvalid, rdata, rresp);
        end
        @(negedge ap_clk);
    endtask

    task automatic test_split_strobe;
        axi_write(8'h34, 32'hCAFEF00D, 4'hF);
        wdata = 32'h11223344; wstrb = 4'h3; wvalid = 1'b1;
        @(negedge ap_clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({bvalid, wready} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL split_wait cycle %0d: got bvalid/wready %b required 00", i, {bvalid, wready});
            end
            if (i < 2) @(negedge ap_clk);
        end
        awaddr = 8'h30; awvalid = 1'b1;
        @(negedge ap_clk);
        awvalid = 1'b0;
        n_tests++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL split_bvalid: got %b required 1", bvalid);
        end
        n_tests++;
        if (dBus !== 64'hCAFEF00D_00003344) begin
            n_fail++;
            $display("[TB] FAIL split_dbus: got %h required cafef00d00003344", dBus);
        end
        @(negedge ap_clk);
    endtask

    task automatic test_start_ready;
        logic [31:0] rd;
        logic [1:0]  rr;
        axi_write(8'h00, 32'h1, 4'hF);
        n_tests++;
        if (ap_start !== 1'b1) begin n_fail++; $display("[TB] FAIL start_set: got %b required 1", ap_start); end
        ap_ready = 1'b1; @(negedge ap_clk); ap_ready = 1'b0;
        n_tests++;
        if (ap_start !== 1'b0) begin n_fail++; $display("[TB] FAIL start_clear: got %b required 0", ap_start); end
        axi_read(8'h00, rd, rr);
        n_tests++;
        if (rd !== 32'h08) begin n_fail++; $display("[TB] FAIL ctrl_ready_read1: got %h required 00000008", rd); end
        axi_read(8'h00, rd, rr);
        n_tests++;
        if (rd !== 32'h00) begin n_fail++; $display("[TB] FAIL ctrl_ready_read2: got %h required 00000000", rd); end
        axi_write(8'h00, 32'h81, 4'hF);
        ap_idle = 1'b1;
        ap_ready = 1'b1; @(negedge ap_clk); ap_ready = 1'b0;
        n_tests++;
        if (ap_start !== 1'b1) begin n_fail++; $display("[TB] FAIL auto_restart_hold: got %b required 1", ap_start); end
        axi_read(8'h00, rd, rr);
        n_tests++;
        if (rd !== 32'h8D) begin n_fail++; $display("[TB] FAIL ctrl_auto_read: got %h required 0000008d", rd); end
        axi_write(8'h00, 32'h00, 4'hF);
        ap_ready = 1'b1; @(negedge ap_clk); ap_ready = 1'b0;
        n_tests++;
        if (ap_start !== 1'b0) begin n_fail++; $display("[TB] FAIL start_clear_after_auto: got %b required 0", ap_start); end
        axi_read(8'h00, rd, rr);
        n_tests++;
        if (rd !== 32'h0C) begin n_fail++; $display("[TB] FAIL ctrl_idle_read: got %h required 0000000c", rd); end
        ap_idle = 1'b0;
    endtask

    task automatic test_interrupt;
        logic [31:0] rd;
        logic [1:0]  rr;
        axi_write(8'h04, 32'h1, 4'hF);
        axi_write(8'h08, 32'h1, 4'hF);
        ap_done = 1'b1; @(negedge ap_clk); ap_done = 1'b0;
        n_tests++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_latency: got %b required 0", interrupt); end
        @(negedge ap_clk);
        n_tests++;
        if (interrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_assert: got %b required 1", interrupt); end
        axi_read(8'h0C, rd, rr);
        n_tests++;
        if (rd !== 32'h1) begin n_fail++; $display("[TB] FAIL isr_set: got %h required 00000001", rd); end
        axi_write(8'h0C, 32'h1, 4'hF);
        n_tests++;
        if (interrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_clear: got %b required 0", interrupt); end
        ap_ready = 1'b1; @(negedge ap_clk); ap_ready = 1'b0;
        axi_read(8'h0C, rd, rr);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL isr_masked_ready: got %h required 00000000", rd); end
        awaddr = 8'h0C; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; ap_done = 1'b1;
        @(negedge ap_clk);
        awvalid = 1'b0; wvalid = 1'b0; ap_done = 1'b0;
        @(negedge ap_clk);
        axi_read(8'h0C, rd, rr);
        n_tests++;
        if (rd !== 32'h1) begin n_fail++; $display("[TB] FAIL isr_set_beats_w1c: got %h required 00000001", rd); end
        axi_write(8'h0C, 32'h1, 4'hF);
        axi_read(8'h00, rd, rr);
        n_tests++;
        if (rd !== 32'h0A) begin n_fail++; $display("[TB] FAIL ctrl_done_ready: got %h required 0000000a", rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        logic [1:0]  rr;
        bready = 1'b0; rready = 1'b0;
        awaddr = 8'h28; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge ap_clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 8'h28; arvalid = 1'b1;
        @(negedge ap_clk);
        arvalid = 1'b0;
        awaddr = 8'h28; wdata = 32'hFFFFFFFF; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({bvalid, rvalid, awready, wready, arready} !== 5'b11000) begin
                n_fail++;
                $display("[TB] FAIL bp_handshake cycle %0d: got %b required 11000", i,
                         {bvalid, rvalid, awready, wready, arready});
            end
            n_tests++;
            if ({rdata, SAMPLE} !== {32'h12345678, 32'h12345678}) begin
                n_fail++;
                $display("[TB] FAIL bp_data cycle %0d: got rdata %h sample %h required 12345678 12345678",
                         i, rdata, SAMPLE);
            end
            @(negedge ap_clk);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        @(negedge ap_clk);
        n_tests++;
        if ({bvalid, rvalid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL bp_release: got bvalid/rvalid %b required 00", {bvalid, rvalid});
        end
        axi_read(8'h7C, rd, rr);
        n_tests++;
        if ({rd, rr} !== 34'd0) begin
            n_fail++;
            $display("[TB] FAIL unmapped_read: got %h resp %b required 00000000 00", rd, rr);
        end
    endtask

    task automatic test_reset_mid;
        axi_write(8'h10, 32'h55AA55AA, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        araddr = 8'h10; arvalid = 1'b1;
        @(negedge ap_clk);
        arvalid = 1'b0; rready = 1'b0;
        n_tests++;
        if ({rvalid, rdata, ap_start} !== {1'b1, 32'h55AA55AA, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL pre_reset: got rvalid %b rdata %h start %b required 1 55aa55aa 1",
                     rvalid, rdata, ap_start);
        end
        #2 ap_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rvalid, ap_start, arready} !== 3'b000 || {rdata, reset_riscv, SAMPLE, dBus} !== 160'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got rvalid %b start %b rdata %h reset_riscv %h required all 0",
                     rvalid, ap_start, rdata, reset_riscv);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1; rready = 1'b1;
        @(negedge ap_clk);
        n_tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL ready_after_mid_reset: got %b required 111", {awready, wready, arready});
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_split_strobe;
        test_start_ready;
        test_interrupt;
        test_backpressure;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
